// File: rtl/motoron_phase_driver.sv
// N-phase BLDC driver: step sequencer, per-phase PWM, dead-time insertion and RUN/BRAKE/IDLE control.
// Define SOFTSTART_EN to ramp the effective duty from 0 on every entry to RUN.
module motoron_phase_driver #(
  parameter int               NPH        = 3,
  parameter int               CNT_W      = 25,
  parameter logic [CNT_W-1:0] STEP_MAX   = 25'd10000,
  parameter logic [CNT_W-1:0] STEP_MIN   = 25'd100,
  parameter logic [CNT_W-1:0] STEP_DELTA = 25'd50,
  parameter int               PWM_W      = 12,
  parameter int               DEAD_CYC   = 20,
  parameter logic [CNT_W-1:0] BRAKE_CYC  = 25'd100000
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3start,
  input  logic             m3forceStop,
  input  logic             m3invRotate,
  input  logic             m3freqINC,
  input  logic             m3freqDEC,
  input  logic [PWM_W-1:0] duty,
  output logic [NPH-1:0]   phHp,
  output logic [NPH-1:0]   phLp,
  output logic             running,
  output logic [3:0]       stepIdx
);

  localparam logic [4:0]       S5          = 5'(2 * NPH);
  localparam logic [3:0]       IDX_LAST    = 4'(2 * NPH - 1);
  localparam logic [3:0]       POS_H_LAST  = 4'(NPH - 2);
  localparam logic [3:0]       POS_L_FIRST = 4'(NPH);
  localparam logic [3:0]       POS_L_LAST  = 4'(2 * NPH - 2);
  localparam logic [7:0]       DEAD        = 8'(DEAD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] PWM_ONE     = {{(PWM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  state_e           state_q;
  logic             running_q;
  logic [CNT_W-1:0] step_len_q;
  logic [CNT_W-1:0] len_pend_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic [CNT_W-1:0] brake_cnt_q;
  logic [3:0]       step_idx_q;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] duty_eff;

  logic             step_end;
  logic             brake_done;
  logic             go_run;
  logic [3:0]       idx_adv;
  logic [CNT_W-1:0] pend_inc;
  logic [CNT_W-1:0] pend_dec;
  logic             pwm_on;

  assign step_end   = (step_cnt_q == step_len_q - CNT_ONE);
  assign brake_done = (brake_cnt_q == BRAKE_CYC - CNT_ONE);
  assign go_run     = m3start && !m3forceStop &&
                      ((state_q == ST_IDLE) || ((state_q == ST_BRAKE) && brake_done));

  // Saturating speed arithmetic, written so neither direction can wrap the counter width.
  assign pend_inc = (len_pend_q >= STEP_MIN + STEP_DELTA) ? len_pend_q - STEP_DELTA : STEP_MIN;
  assign pend_dec = (len_pend_q >= STEP_MAX - STEP_DELTA) ? STEP_MAX : len_pend_q + STEP_DELTA;

  // Direction is sampled at each step boundary and steers that boundary's advance.
  always_comb begin
    if (m3invRotate) begin
      idx_adv = (step_idx_q == 4'd0) ? IDX_LAST : step_idx_q - 4'd1;
    end else begin
      idx_adv = (step_idx_q == IDX_LAST) ? 4'd0 : step_idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      step_len_q  <= STEP_MAX;
      len_pend_q  <= STEP_MAX;
      step_cnt_q  <= '0;
      brake_cnt_q <= '0;
      step_idx_q  <= '0;
    end else begin
      if ((state_q == ST_RUN) && (m3freqINC ^ m3freqDEC)) begin
        len_pend_q <= m3freqINC ? pend_inc : pend_dec;
      end
      unique case (state_q)
        ST_RUN: begin
          if (m3forceStop) begin
            state_q     <= ST_BRAKE;
            running_q   <= 1'b0;
            brake_cnt_q <= '0;
          end else if (!m3start) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (step_end) begin
            step_cnt_q <= '0;
            step_idx_q <= idx_adv;
            step_len_q <= len_pend_q;
          end else begin
            step_cnt_q <= step_cnt_q + CNT_ONE;
          end
        end
        ST_BRAKE: begin
          if (brake_done) begin
            state_q <= ST_IDLE;
          end else begin
            brake_cnt_q <= brake_cnt_q + CNT_ONE;
          end
        end
        default: begin
          if (m3forceStop) begin
            state_q     <= ST_BRAKE;
            brake_cnt_q <= '0;
          end
        end
      endcase
      if (go_run) begin
        state_q    <= ST_RUN;
        running_q  <= 1'b1;
        step_len_q <= STEP_MAX;
        len_pend_q <= STEP_MAX;
        step_cnt_q <= '0;
        step_idx_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
    end
  end

`ifdef SOFTSTART_EN
  logic [PWM_W-1:0] soft_duty_q;
  logic             ramp_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      soft_duty_q <= '0;
      ramp_q      <= 1'b0;
    end else if (go_run) begin
      soft_duty_q <= '0;
      ramp_q      <= 1'b1;
    end else if (ramp_q) begin
      if (soft_duty_q >= duty) begin
        ramp_q <= 1'b0;
      end else if (pwm_cnt_q == '1) begin
        soft_duty_q <= soft_duty_q + PWM_ONE;
      end
    end
  end

  assign duty_eff = ramp_q ? soft_duty_q : duty;
`else
  assign duty_eff = duty;
`endif

  assign pwm_on = (pwm_cnt_q < duty_eff);

  for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
    localparam logic [4:0] OFS = 5'(2 * gi);

    logic [4:0] pos_sum;
    logic [3:0] pos;
    logic       is_high;
    logic       is_low;
    logic       req_h;
    logic       req_l;
    logic       h_d;
    logic       l_d;
    logic       h_q;
    logic       l_q;
    logic [7:0] h_off_q;
    logic [7:0] l_off_q;

    // Position of this phase inside its own electrical cycle, 2*gi steps behind phase 0.
    assign pos_sum = {1'b0, step_idx_q} + S5 - OFS;
    assign pos     = (pos_sum >= S5) ? 4'(pos_sum - S5) : pos_sum[3:0];
    assign is_high = (pos <= POS_H_LAST);
    assign is_low  = (pos >= POS_L_FIRST) && (pos <= POS_L_LAST);

    always_comb begin
      req_h = 1'b0;
      req_l = 1'b0;
      unique case (state_q)
        ST_RUN: begin
          req_h = is_high && pwm_on;
          req_l = is_low;
        end
        ST_BRAKE: req_l = 1'b1;
        default: ;
      endcase
    end

    // Turn-off is immediate; turn-on waits until the opposite device has been off long enough.
    assign h_d = req_h && (h_q || (l_off_q >= DEAD));
    assign l_d = req_l && (l_q || (h_off_q >= DEAD));

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        h_q     <= 1'b0;
        l_q     <= 1'b0;
        h_off_q <= '0;
        l_off_q <= '0;
      end else begin
        h_q     <= h_d;
        l_q     <= l_d;
        h_off_q <= h_d ? 8'd0 : ((h_off_q >= DEAD) ? DEAD : h_off_q + 8'd1);
        l_off_q <= l_d ? 8'd0 : ((l_off_q >= DEAD) ? DEAD : l_off_q + 8'd1);
      end
    end

    assign phHp[gi] = h_q;
    assign phLp[gi] = l_q;
  end

  assign running = running_q;
  assign stepIdx = step_idx_q;

endmodule

// File: doc/motoron_phase_driver.md
Name: motoron_phase_driver

Overview:
- Parametrised N-phase brushless motor driver. Generalises the fixed 3-phase top level to NPH half-bridges.
- Integrates the step sequencer, per-phase PWM, dead-time insertion, and a run/brake/idle controller.
- Implements the forced-stop (brake) and reverse-rotation modes as real behaviour.
- Sits between the control inputs (start/stop/inc/dec) and the gate-driver pins.

Parameters:
- NPH, 3, number of phases; legal range 3..8; electrical cycle S = 2*NPH steps.
- CNT_W, 25, width of step-length counter and step-length register.
- STEP_MAX, 25'd10000, slowest step length in clk cycles; the start value.
- STEP_MIN, 25'd100, fastest step length in clk cycles.
- STEP_DELTA, 25'd50, step-length change per INC/DEC pulse.
- PWM_W, 12, PWM counter and duty width; PWM period = 2^PWM_W clocks.
- DEAD_CYC, 20, dead-time in clocks, 1..255.
- BRAKE_CYC, 25'd100000, brake duration in clocks.

Ports:
- clk  in  1  system clock (10 MHz).
- nRst  in  1  asynchronous active-low reset.
- m3start  in  1  level; 1 = run request.
- m3forceStop  in  1  level; 1 = brake request; has priority over m3start.
- m3invRotate  in  1  level; 1 = reverse step direction.
- m3freqINC  in  1  single-cycle pulse; raises speed.
- m3freqDEC  in  1  single-cycle pulse; lowers speed.
- duty  in  PWM_W  high-side PWM compare value.
- phHp  out  NPH  high-side gate enables; bit k = phase k.
- phLp  out  NPH  low-side gate enables.
- running  out  1  1 while in RUN.
- stepIdx  out  4  current commutation step, 0..S-1.

Behaviour:
- Reset (async, nRst=0):
  - state=IDLE; phHp=0, phLp=0, running=0, stepIdx=0.
  - stepLen=STEP_MAX; stepCnt=0; pwmCnt=0; dir=0; all dead-time counters=0.
- State IDLE: all requested drives off.
  - m3forceStop=1 -> BRAKE.
  - else m3start=1 -> RUN, with stepLen=STEP_MAX, stepCnt=0, stepIdx=0, dir latched from m3invRotate.
- State RUN: running=1.
  - stepCnt increments each clk. At stepCnt==stepLen-1 it clears and stepIdx advances.
  - Advance is +1 mod S when dir=0, -1 mod S when dir=1; 0->S-1 wraps when dir=1.
  - dir re-latches from m3invRotate only at step boundaries.
  - m3forceStop=1 -> BRAKE (same cycle as seen). m3start=0 -> IDLE (coast).
- State BRAKE: requested phLp=all 1, phHp=all 0.
  - Lasts BRAKE_CYC clocks, then -> IDLE; if m3start=1 and m3forceStop=0 at expiry, -> RUN instead.
  - A new m3forceStop during BRAKE does not restart the timer.
- Speed, evaluated only in RUN; pulses are ignored in IDLE and BRAKE:
  - INC alone: stepLen = max(stepLen-STEP_DELTA, STEP_MIN), with no underflow.
  - DEC alone: stepLen = min(stepLen+STEP_DELTA, STEP_MAX).
  - INC and DEC in the same cycle: no change.
  - A new stepLen applies at the next step boundary; the current step completes with the old length.
- Phase pattern, phase k, with p = (stepIdx - 2k) mod S:
  - p in 0..NPH-2: HIGH.
  - p == NPH-1: FLOAT.
  - p in NPH..2NPH-2: LOW.
  - p == 2NPH-1: FLOAT.
  - For NPH=3: steps H,H,F,L,L,F, with phases offset by 2 steps (120 deg).
- Drive request per phase:
  - HIGH: reqH = (pwmCnt < duty), reqL=0.
  - LOW: reqL=1, reqH=0.
  - FLOAT: both 0.
  - duty=0 gives reqH always 0. pwmCnt free-runs and wraps at 2^PWM_W-1.
- Dead time, per phase and per device:
  - A falling request propagates to the output next clk.
  - A rising request propagates only after the opposite device of that phase has been off for DEAD_CYC consecutive clocks.
  - Output is registered, so latency from request to output is 1 clk minimum.
- Invariant: phHp[k] & phLp[k] == 0 on every cycle, including state changes and reset release.

Optional Feature:
- Macro SOFTSTART_EN.
- Defined:
  - On entry to RUN, effective duty starts at 0 and increments by 1 at each pwmCnt wrap until it equals the duty input.
  - It then tracks duty directly. Any re-entry to RUN restarts the ramp.
- Undefined: effective duty = duty input immediately.

Test Plan:
- Reset: nRst=0 mid-RUN with outputs active -> all outputs 0 on the same cycle, and stepIdx=0 after release.
- NPH=3, STEP_MAX=100, duty=4095, m3start=1:
  - stepIdx goes 0..5 every 100 clk.
  - Phase0 runs H,H,F,L,L,F; phases 1 and 2 lag by 200 and 400 clk.
- Dead time: at the phase0 transition H->F->L, phLp[0] rises no earlier than DEAD_CYC=20 clk after phHp[0] falls; Hp&Lp never both 1 (checked every cycle).
- Speed: 300 INC pulses -> stepLen saturates at 100; 1 INC+DEC same cycle -> unchanged; 500 DEC -> 10000.
- Reverse: m3invRotate=1 mid-step at stepIdx=3 -> current step finishes, then stepIdx goes 2,1,0,5.
- Brake: m3forceStop=1 in RUN -> phHp=0 next clk, phLp=3'b111 after dead-time, IDLE after BRAKE_CYC; SOFTSTART_EN build shows duty ramping 0->duty over duty PWM periods.
